data_sram_responder: RTL and testbench

//  Responder end of the CPU's data SRAM interface: a synchronous, byte-writable word RAM that

---
 rtl/data_sram_responder.sv | 119 +++++++++++
 tb/tb_data_sram_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// data_sram_responder: responder end of the CPU data SRAM port.
// Synchronous byte-writable word RAM with one-cycle read latency and
// read-first behaviour on writes. Out-of-window accesses read as zero,
// drop writes and set a sticky error flag.
// Build option: define SRAM_TIMER_EN to map a free-running 32-bit timer
// at TIMER_ADDR (it shadows a RAM word if TIMER_ADDR lies in the window).
//
// Request protocol: there is no valid/ready handshake. Every cycle with
// data_sram_en=1 is one accepted request; the responder never stalls.
// Read data for a request appears on data_sram_rdata after the next
// rising edge and holds until the next accepted request or reset.
module data_sram_responder #(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] TIMER_ADDR = 32'hBFAF_E100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        err_sticky
);

    localparam int          DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [31:0] WIN_MASK = ~(32'(4 * DEPTH) - 32'd1);

    logic [31:0]           mem_q [DEPTH];
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  hit_ram;
    logic                  hit_tmr;
    logic                  ram_wr;
    logic [31:0]           tmr_rd;
    logic                  unused_bits;

    // Byte lanes come from wen, so the low address bits carry no information.
    assign unused_bits = ^{data_sram_addr[1:0], TIMER_ADDR[1:0]};

`ifdef SRAM_TIMER_EN
    logic [31:0] timer_q, timer_d;

    // Timer next value: a full-word write to the timer wins over the increment.
    always_comb begin
        timer_d = timer_q + 32'd1;
        if (data_sram_en && hit_tmr && (data_sram_wen == 4'hF)) begin
            timer_d = data_sram_wdata;
        end
    end

    // Timer register, free-running from zero after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign hit_tmr = (data_sram_addr[31:2] == TIMER_ADDR[31:2]);
    assign tmr_rd  = timer_q;
`else
    assign hit_tmr = 1'b0;
    assign tmr_rd  = '0;
`endif

    // Address decode: timer takes priority over the RAM window.
    always_comb begin
        word_idx = data_sram_addr[DEPTH_LOG2+1:2];
        hit_ram  = ((data_sram_addr & WIN_MASK) == BASE_ADDR);
        ram_wr   = rst_n && data_sram_en && hit_ram && !hit_tmr
                   && (data_sram_wen != 4'h0);
    end

    // Read data and sticky error next state; idle cycles hold both.
    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (data_sram_en) begin
            if (hit_tmr) begin
                rdata_d = tmr_rd;
            end else if (hit_ram) begin
                rdata_d = mem_q[word_idx];
            end else begin
                rdata_d = '0;
                err_d   = 1'b1;
            end
        end
    end

    // RAM array: per-byte writes, contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_wen[b]) begin
                    mem_q[word_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    // Output registers: read data and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign data_sram_rdata = rdata_q;
    assign err_sticky      = err_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: directed vectors, a behavioural model
// of the RAM/timer checked every cycle, plus literal expectations.
module tb_data_sram_responder;

    localparam logic [31:0] BASE     = 32'h0000_0000;
    localparam logic [31:0] TMR      = 32'hBFAF_E100;
    localparam longint      WIN_SIZE = 4 * 4096;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;

    int n_vec;
    int n_bad;

    data_sram_responder dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .err_sticky      (err)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mem_m [int];
    bit          known_m [int];
    logic [31:0] m_rdata;
    bit          m_rdata_known;
    logic        m_err;
    logic [31:0] m_timer;
    bit          m_valid;

    initial begin
        m_valid       = 0;
        m_rdata_known = 0;
        m_rdata       = '0;
        m_err         = 1'b0;
        m_timer       = '0;
    end

    always @(posedge clk) begin
        logic [31:0] next_timer;
        logic [31:0] word;
        bit          tmr_hit;
        bit          ram_hit;
        int          widx;
        if (!rst_n) begin
            m_rdata       = '0;
            m_rdata_known = 1;
            m_err         = 1'b0;
            m_timer       = '0;
            m_valid       = 1;
        end else begin
            next_timer = m_timer + 32'd1;
            if (en) begin
`ifdef SRAM_TIMER_EN
                tmr_hit = ((addr >> 2) == (TMR >> 2));
`else
                tmr_hit = 0;
`endif
                ram_hit = (longint'(addr) >= longint'(BASE)) &&
                          (longint'(addr) < longint'(BASE) + WIN_SIZE);
                widx    = int'((addr - BASE) >> 2);
                if (tmr_hit) begin
                    m_rdata       = m_timer;
                    m_rdata_known = 1;
                    if (wen == 4'hF) next_timer = wdata;
                end else if (ram_hit) begin
                    if (known_m.exists(widx) && known_m[widx]) begin
                        word          = mem_m[widx];
                        m_rdata       = word;
                        m_rdata_known = 1;
                    end else begin
                        word          = '0;
                        m_rdata_known = 0;
                    end
                    if (wen != 4'h0) begin
                        for (int b = 0; b < 4; b++)
                            if (wen[b]) word[8*b +: 8] = wdata[8*b +: 8];
                        mem_m[widx] = word;
                        known_m[widx] = (known_m.exists(widx) && known_m[widx]) || (wen == 4'hF);
                    end
                end else begin
                    m_rdata       = '0;
                    m_rdata_known = 1;
                    m_err         = 1'b1;
                end
            end
            m_timer = next_timer;
        end
    end

    // Compare process: outputs checked against the model every cycle.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_err", {31'd0, err}, {31'd0, m_err});
            if (m_rdata_known) check("model_rdata", rdata, m_rdata);
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en    = e;
        wen   = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        wen   = 4'h0;
        addr  = '0;
        wdata = '0;
        idle();
        step(1'b1, 4'h0, 32'h10, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_err", {31'd0, err}, 32'h0);
        rst_n = 1'b1;

        // Test 1: read after reset returns zero, no error.
        step(1'b1, 4'hF, 32'h10, 32'h0);
        step(1'b1, 4'h0, 32'h10, 32'h0);
        check("t1_read", rdata, 32'h0);
        check("t1_err", {31'd0, err}, 32'h0);

        // Test 2: byte lanes and read-first.
        step(1'b1, 4'hF, 32'h20, 32'h1122_3344);
        step(1'b1, 4'h1, 32'h20, 32'h0000_00AA);
        check("t2_read_first", rdata, 32'h1122_3344);
        step(1'b1, 4'h0, 32'h20, 32'h0);
        check("t2_merge", rdata, 32'h1122_33AA);
        step(1'b1, 4'hA, 32'h20, 32'hFFFF_FFFF);
        check("t2_read_first2", rdata, 32'h1122_33AA);
        step(1'b1, 4'h0, 32'h23, 32'h0);
        check("t2_lanes_1010", rdata, 32'hFF22_FFAA);

        // Test 3: write then immediate read, then hold with en=0.
        step(1'b1, 4'hF, 32'h40, 32'hDEAD_BEEF);
        step(1'b1, 4'h0, 32'h40, 32'h0);
        check("t3_b2b", rdata, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'hF, 32'h20, 32'h5555_5555);
            check("t3_hold", rdata, 32'hDEAD_BEEF);
        end

        // Window boundaries: last word hits, first word past it misses.
        step(1'b1, 4'hF, 32'h0, 32'h0101_0101);
        step(1'b1, 4'hF, 32'h3FFC, 32'hA5A5_A5A5);
        step(1'b1, 4'h0, 32'h3FFC, 32'h0);
        check("top_word", rdata, 32'hA5A5_A5A5);
        check("top_word_err", {31'd0, err}, 32'h0);
        step(1'b1, 4'hF, 32'h60, 32'h1234_5678);

        // Test 4: misses read zero, set err, and drop writes.
        step(1'b1, 4'h0, 32'h8000_0000, 32'h0);
        check("t4_miss_rdata", rdata, 32'h0);
        check("t4_miss_err", {31'd0, err}, 32'h1);
        step(1'b1, 4'hF, 32'h8000_0000, 32'hCAFE_F00D);
        step(1'b1, 4'hF, 32'h8000_0020, 32'hCAFE_F00D);
        step(1'b1, 4'hF, 32'h4000, 32'hCAFE_F00D);
        step(1'b1, 4'h0, 32'h0, 32'h0);
        check("t4_ram0", rdata, 32'h0101_0101);
        step(1'b1, 4'h0, 32'h20, 32'h0);
        check("t4_ram20", rdata, 32'hFF22_FFAA);
        step(1'b1, 4'h0, 32'h4000, 32'h0);
        check("t4_past_top", rdata, 32'h0);

        // Test 6 (with the reset pulse of test 4): write during reset is dropped.
        rst_n = 1'b0;
        step(1'b1, 4'hF, 32'h60, 32'h0000_0005);
        rst_n = 1'b1;
        check("t4_err_cleared", {31'd0, err}, 32'h0);
        check("t6_rdata_reset", rdata, 32'h0);
        step(1'b1, 4'h0, 32'h60, 32'h0);
        check("t6_preserved", rdata, 32'h1234_5678);

`ifdef SRAM_TIMER_EN
        // Test 5: timer load, wrap, partial write ignored.
        step(1'b1, 4'hF, TMR, 32'hFFFF_FFFE);
        step(1'b1, 4'h0, TMR, 32'h0);
        check("t5_load", rdata, 32'hFFFF_FFFE);
        step(1'b1, 4'h0, TMR, 32'h0);
        check("t5_inc", rdata, 32'hFFFF_FFFF);
        step(1'b1, 4'h0, TMR, 32'h0);
        check("t5_wrap", rdata, 32'h0);
        step(1'b1, 4'h3, TMR, 32'h0000_7777);
        check("t5_partial_rd", rdata, 32'h1);
        step(1'b1, 4'h0, TMR, 32'h0);
        check("t5_no_load", rdata, 32'h2);
        check("t5_no_err", {31'd0, err}, 32'h0);
`else
        // Without the timer, TIMER_ADDR is outside the window: a plain miss.
        step(1'b1, 4'hF, TMR, 32'hFFFF_FFFE);
        check("tmr_off_wr_err", {31'd0, err}, 32'h1);
        step(1'b1, 4'h0, TMR, 32'h0);
        check("tmr_off_rd", rdata, 32'h0);
`endif
        idle();
        idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
